// File: rtl/lisnoc_arb_pkg.sv
// Shared types and helpers for the LISNoC output-port arbiters.
// Holds flit type encodings, arbiter states and a round-robin pick function.
package lisnoc_arb_pkg;

    typedef enum logic [1:0] {
        FLIT_PAYLOAD = 2'b00,
        FLIT_HEADER  = 2'b01,
        FLIT_LAST    = 2'b10,
        FLIT_SINGLE  = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int MAX_PORTS = 32;
    localparam int MAX_IDX_W = 5;

    // Picks the first set request after 'last', wrapping at 'ports'; result is one-hot or zero.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input int unsigned          last,
        input int unsigned          ports = MAX_PORTS
    );
        logic [MAX_PORTS-1:0] pick;
        logic [MAX_IDX_W-1:0] idx;
        logic                 found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
            if (i <= ports) begin
                idx = MAX_IDX_W'((last + i) % ports);
                if (!found && req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lisnoc_rr_select.sv
// Combinational round-robin selector: one-hot pick of the first request after 'last',
// plus the encoded index of that pick and a flag telling whether anything was picked.
module lisnoc_rr_select #(
    parameter  int PORTS = 5,
    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [PORTS-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    int cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        cand     = 0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = int'(last) + i;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            if (!any && req[cand[IDX_W-1:0]]) begin
                pick[cand[IDX_W-1:0]] = 1'b1;
                pick_idx              = cand[IDX_W-1:0];
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_wormhole_arbiter.sv
// Wormhole arbiter for one router output port: round-robin grant locked from header to last flit,
// with protocol-violation pulses and an optional starvation watchdog.
module lisnoc_wormhole_arbiter
    import lisnoc_arb_pkg::*;
#(
    parameter  int FLIT_DATA_WIDTH = 32,
    parameter  int FLIT_TYPE_WIDTH = 2,
    parameter  int PORTS           = 5,
    parameter  int STALL_LIMIT     = 0,
    localparam int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
    localparam int IDX_W           = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*FLIT_WIDTH-1:0] req_flit,
    input  logic [PORTS-1:0]            req_valid,
    output logic [PORTS-1:0]            req_ready,
    output logic [FLIT_WIDTH-1:0]       out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PORTS-1:0]            grant,
    output logic                        locked,
    output logic                        proto_err,
    output logic                        stall_err
);

    arb_state_t            state, state_next;
    logic [IDX_W-1:0]      last_winner;
    logic                  first_flit;
    logic [PORTS-1:0]      eligible, misplaced, pick;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  sel_valid;
    flit_type_t            sel_type;
    logic                  xfer, sel_closes;
    logic [1:0]            ptype;

    // Only packet-opening flits may compete; body flits seen while idle are misplaced.
    always_comb begin
        eligible  = '0;
        misplaced = '0;
        ptype     = '0;
        for (int p = 0; p < PORTS; p++) begin
            ptype = req_flit[p*FLIT_WIDTH+FLIT_WIDTH-2 +: 2];
            if (req_valid[p]) begin
                if (ptype == FLIT_HEADER || ptype == FLIT_SINGLE) begin
                    eligible[p] = 1'b1;
                end else begin
                    misplaced[p] = 1'b1;
                end
            end
        end
    end

    lisnoc_rr_select #(
        .PORTS (PORTS)
    ) u_rr_select (
        .req      (eligible),
        .last     (last_winner),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        sel_flit  = '0;
        sel_valid = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (grant[p]) begin
                sel_flit  = sel_flit | req_flit[p*FLIT_WIDTH +: FLIT_WIDTH];
                sel_valid = sel_valid | req_valid[p];
            end
        end
    end

    assign sel_type   = flit_type_t'(sel_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH]);
    assign sel_closes = (sel_type == FLIT_LAST) || (sel_type == FLIT_SINGLE);
    assign xfer       = (state == LOCKED) && sel_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = LOCKED;
            LOCKED:  if (xfer && sel_closes) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_flit  = '0;
        out_valid = 1'b0;
        req_ready = '0;
        locked    = 1'b0;
        proto_err = 1'b0;
        case (state)
            IDLE: proto_err = |misplaced;
            LOCKED: begin
                locked    = 1'b1;
                out_flit  = sel_flit;
                out_valid = sel_valid;
                req_ready = grant & {PORTS{out_ready}};
                proto_err = xfer && (sel_type == FLIT_HEADER) && !first_flit;
            end
            default: ;
        endcase
    end

    // first_flit marks that the opening flit of the lock has not yet been transferred.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant       <= '0;
            last_winner <= IDX_W'(PORTS-1);
            first_flit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant       <= pick;
                        last_winner <= pick_idx;
                        first_flit  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (xfer) first_flit <= 1'b0;
                    if (xfer && sel_closes) grant <= '0;
                end
                default: grant <= '0;
            endcase
        end
    end

    generate
        if (STALL_LIMIT > 0) begin : g_watchdog
            localparam int              CNT_W = $clog2(STALL_LIMIT+1);
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);
            logic [CNT_W-1:0] stall_cnt, stall_cnt_next;

            // Back-pressured cycles are not starvation, so they neither count nor clear.
            always_comb begin
                stall_cnt_next = stall_cnt;
                if (state != LOCKED || sel_valid) begin
                    stall_cnt_next = '0;
                end else if (out_ready && stall_cnt != LIMIT) begin
                    stall_cnt_next = stall_cnt + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stall_cnt <= '0;
                    stall_err <= 1'b0;
                end else begin
                    stall_cnt <= stall_cnt_next;
                    if (stall_cnt_next == LIMIT) stall_err <= 1'b1;
                end
            end
        end else begin : g_no_watchdog
            assign stall_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_lisnoc_wormhole_arbiter.sv
// Directed bench for lisnoc_wormhole_arbiter: arbitration order, locking, back-pressure,
// watchdog, protocol errors and asynchronous reset mid-packet.
module tb_lisnoc_wormhole_arbiter;

    localparam int FW = 34;
    localparam int NP = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*FW-1:0] req_flit;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_ready;
    logic [FW-1:0]    out_flit;
    logic             out_valid;
    logic             out_ready;
    logic [NP-1:0]    grant;
    logic             locked;
    logic             proto_err;
    logic             stall_err;

    int               checks = 0;
    int               errors = 0;
    int               pos [NP];
    logic [NP-1:0]    rdy;
    int               exp_port [13] = '{-1, 0, 0, 0, -1, 1, 1, 1, -1, 3, 3, 3, -1};
    int               exp_k    [13] = '{0, 0, 1, 2, 0, 0, 1, 2, 0, 0, 1, 2, 0};
    logic [FW-1:0]    exp_flit;
    logic [NP-1:0]    exp_grant;

    lisnoc_wormhole_arbiter #(
        .FLIT_DATA_WIDTH (32),
        .FLIT_TYPE_WIDTH (2),
        .PORTS           (NP),
        .STALL_LIMIT     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_flit  (req_flit),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .locked    (locked),
        .proto_err (proto_err),
        .stall_err (stall_err)
    );

    always #5 clk = ~clk;

    // Flit k of a three-flit packet from port p: HEADER, PAYLOAD, LAST.
    function automatic logic [FW-1:0] mk(input int p, input int k);
        logic [1:0] t;
        t = (k == 0) ? 2'b01 : ((k == 1) ? 2'b00 : 2'b10);
        return {t, 32'hA000_0000 + 32'(p*16 + k)};
    endfunction

    task automatic applyStimulus(input int p, input logic [FW-1:0] flit, input logic v);
        req_flit[p*FW +: FW] = flit;
        req_valid[p]         = v;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        #1;
        rst       = 1'b0;
        req_valid = '0;
        req_flit  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_flit  = '0;
        out_ready = 1'b1;
        #2;
        rst = 1'b0;
        #2;
        checkOutput("rst out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst grant",     64'(grant),     64'(0));
        checkOutput("rst req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst locked",    64'(locked),    64'(0));
        checkOutput("rst out_flit",  64'(out_flit),  64'(0));
        checkOutput("rst proto_err", 64'(proto_err), 64'(0));
        checkOutput("rst stall_err", 64'(stall_err), 64'(0));

        // Single-flit packet on port 2
        do_reset();
        applyStimulus(2, {2'b11, 32'hDEADBEEF}, 1'b1);
        #1;
        checkOutput("t1 idle out_valid", 64'(out_valid), 64'(0));
        checkOutput("t1 idle grant",     64'(grant),     64'(0));
        tick();
        checkOutput("t1 grant",     64'(grant),     64'(5'b00100));
        checkOutput("t1 out_valid", 64'(out_valid), 64'(1));
        checkOutput("t1 out_flit",  64'(out_flit),  64'({2'b11, 32'hDEADBEEF}));
        checkOutput("t1 req_ready", 64'(req_ready), 64'(5'b00100));
        checkOutput("t1 locked",    64'(locked),    64'(1));
        tick();
        applyStimulus(2, '0, 1'b0);
        #1;
        checkOutput("t1 release locked", 64'(locked), 64'(0));
        checkOutput("t1 release grant",  64'(grant),  64'(0));

        // Three simultaneous 3-flit packets on ports 0, 1, 3
        do_reset();
        for (int p = 0; p < NP; p++) pos[p] = 3;
        pos[0] = 0;
        pos[1] = 0;
        pos[3] = 0;
        for (int c = 0; c < 13; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (pos[p] < 3) applyStimulus(p, mk(p, pos[p]), 1'b1);
                else            applyStimulus(p, '0, 1'b0);
            end
            #1;
            exp_grant = (exp_port[c] < 0) ? '0 : NP'(1 << exp_port[c]);
            exp_flit  = (exp_port[c] < 0) ? '0 : mk(exp_port[c], exp_k[c]);
            checkOutput($sformatf("t2 c%0d grant", c),    64'(grant),    64'(exp_grant));
            checkOutput($sformatf("t2 c%0d out_flit", c), 64'(out_flit), 64'(exp_flit));
            rdy = req_ready;
            tick();
            for (int p = 0; p < NP; p++) begin
                if (rdy[p] && pos[p] < 3) pos[p]++;
            end
        end

        // Back-pressure in the middle of a port-1 packet
        do_reset();
        applyStimulus(1, mk(1, 0), 1'b1);
        tick();
        tick();
        applyStimulus(1, mk(1, 1), 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("t3 bp%0d req_ready", i), 64'(req_ready), 64'(0));
            checkOutput($sformatf("t3 bp%0d out_flit", i),  64'(out_flit),  64'(mk(1, 1)));
            checkOutput($sformatf("t3 bp%0d out_valid", i), 64'(out_valid), 64'(1));
            checkOutput($sformatf("t3 bp%0d stall_err", i), 64'(stall_err), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("t3 resume req_ready", 64'(req_ready), 64'(5'b00010));
        tick();
        applyStimulus(1, mk(1, 2), 1'b1);
        #1;
        checkOutput("t3 last out_flit", 64'(out_flit), 64'(mk(1, 2)));
        tick();
        applyStimulus(1, '0, 1'b0);
        #1;
        checkOutput("t3 end locked",    64'(locked),    64'(0));
        checkOutput("t3 end stall_err", 64'(stall_err), 64'(0));

        // Misplaced PAYLOAD on port 0 while a HEADER on port 3 arrives
        do_reset();
        applyStimulus(0, mk(0, 1), 1'b1);
        applyStimulus(3, mk(3, 0), 1'b1);
        #1;
        checkOutput("t5 idle proto_err", 64'(proto_err), 64'(1));
        checkOutput("t5 idle grant",     64'(grant),     64'(0));
        checkOutput("t5 idle out_valid", 64'(out_valid), 64'(0));
        tick();
        checkOutput("t5 grant",           64'(grant),     64'(5'b01000));
        checkOutput("t5 first proto_err", 64'(proto_err), 64'(0));
        tick();
        applyStimulus(3, {2'b01, 32'hBAD0_0003}, 1'b1);
        #1;
        checkOutput("t5 dup header proto_err", 64'(proto_err), 64'(1));
        checkOutput("t5 dup header out_flit",  64'(out_flit),  64'({2'b01, 32'hBAD0_0003}));
        checkOutput("t5 dup header ready",     64'(req_ready), 64'(5'b01000));
        tick();
        applyStimulus(3, mk(3, 2), 1'b1);
        applyStimulus(0, '0, 1'b0);
        #1;
        checkOutput("t5 last proto_err", 64'(proto_err), 64'(0));
        tick();
        applyStimulus(3, '0, 1'b0);
        #1;
        checkOutput("t5 end locked",    64'(locked),    64'(0));
        checkOutput("t5 end proto_err", 64'(proto_err), 64'(0));

        // Starvation watchdog on port 4
        do_reset();
        applyStimulus(4, mk(4, 0), 1'b1);
        tick();
        checkOutput("t4 grant", 64'(grant), 64'(5'b10000));
        tick();
        applyStimulus(4, mk(4, 1), 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("t4 bp%0d stall_err", i), 64'(stall_err), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("t4 starve%0d stall_err", i), 64'(stall_err), 64'(0));
            checkOutput($sformatf("t4 starve%0d locked", i),    64'(locked),    64'(1));
            tick();
        end
        checkOutput("t4 stall_err set",  64'(stall_err), 64'(1));
        checkOutput("t4 still locked",   64'(locked),    64'(1));
        applyStimulus(4, mk(4, 2), 1'b1);
        #1;
        checkOutput("t4 last out_valid", 64'(out_valid), 64'(1));
        tick();
        applyStimulus(4, '0, 1'b0);
        #1;
        checkOutput("t4 end locked",    64'(locked),    64'(0));
        checkOutput("t4 end stall_err", 64'(stall_err), 64'(1));

        // Asynchronous reset while port 2 is mid-packet
        do_reset();
        checkOutput("t6 reset clears stall_err", 64'(stall_err), 64'(0));
        applyStimulus(2, mk(2, 0), 1'b1);
        tick();
        tick();
        applyStimulus(2, mk(2, 1), 1'b1);
        #1;
        checkOutput("t6 pre out_valid", 64'(out_valid), 64'(1));
        checkOutput("t6 pre grant",     64'(grant),     64'(5'b00100));
        rst = 1'b0;
        #1;
        checkOutput("t6 async out_valid", 64'(out_valid), 64'(0));
        checkOutput("t6 async grant",     64'(grant),     64'(0));
        checkOutput("t6 async req_ready", 64'(req_ready), 64'(0));
        checkOutput("t6 async locked",    64'(locked),    64'(0));
        req_valid = '0;
        tick();
        rst = 1'b1;
        applyStimulus(0, mk(0, 0), 1'b1);
        applyStimulus(2, mk(2, 0), 1'b1);
        #1;
        checkOutput("t6 idle grant", 64'(grant), 64'(0));
        tick();
        checkOutput("t6 priority grant",    64'(grant),    64'(5'b00001));
        checkOutput("t6 priority out_flit", 64'(out_flit), 64'(mk(0, 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
